// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants and the stall/flush control bundle for the hazard scoreboard.
package hazard_scoreboard_pkg;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic flush_d;
      logic flush_e;
   } hz_ctrl_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard signal bundle. Perf ports exist only with HAZARD_PERF_EN.
interface hazard_scoreboard_if;
   import hazard_scoreboard_pkg::*;

   reg_idx_t    i_rs1_d;
   reg_idx_t    i_rs2_d;
   logic        i_rs1_used_d;
   logic        i_rs2_used_d;
   reg_idx_t    i_rd_d;
   logic        i_w_en_d;
   logic        i_long_d;
   reg_idx_t    i_rd_e;
   logic        i_w_en_e;
   logic        i_mem_read_e;
   logic        i_long_e;
   logic        i_branch_taken_e;
   logic        i_long_done;
   reg_idx_t    i_long_done_idx;
   logic        o_stall_f;
   logic        o_stall_d;
   logic        o_flush_d;
   logic        o_flush_e;
   logic        o_busy;
   logic        o_err;
`ifdef HAZARD_PERF_EN
   logic [31:0] o_stall_cycles;
   logic [15:0] o_flush_count;
`endif

   modport master (
      output i_rs1_d, i_rs2_d, i_rs1_used_d, i_rs2_used_d, i_rd_d, i_w_en_d, i_long_d,
             i_rd_e, i_w_en_e, i_mem_read_e, i_long_e, i_branch_taken_e,
             i_long_done, i_long_done_idx,
`ifdef HAZARD_PERF_EN
      input  o_stall_cycles, o_flush_count,
`endif
      input  o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_busy, o_err
   );

   modport slave (
      input  i_rs1_d, i_rs2_d, i_rs1_used_d, i_rs2_used_d, i_rd_d, i_w_en_d, i_long_d,
             i_rd_e, i_w_en_e, i_mem_read_e, i_long_e, i_branch_taken_e,
             i_long_done, i_long_done_idx,
`ifdef HAZARD_PERF_EN
      output o_stall_cycles, o_flush_count,
`endif
      output o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_busy, o_err
   );
endinterface

// File: rtl/hazard_scoreboard_sb_pending_vec.sv
// Per-register pending vector with outstanding counter; lookups see the same-cycle clear.
module sb_pending_vec
   import hazard_scoreboard_pkg::*;
#(
   parameter  int MAX_OUTSTANDING = 4,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_set_en,
   input  reg_idx_t         i_set_idx,
   input  logic             i_clr_req,
   input  reg_idx_t         i_clr_idx,
   input  reg_idx_t         i_rs1,
   input  reg_idx_t         i_rs2,
   input  reg_idx_t         i_rd,
   output logic             o_pend_rs1,
   output logic             o_pend_rs2,
   output logic             o_pend_rd,
   output logic             o_clr_valid,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_err
);
   logic [NUM_REGS-1:0] r_pending;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;
   logic [NUM_REGS-1:0] w_pend_eff;
   logic [NUM_REGS-1:0] w_pend_next;
   logic                w_clr_valid;
   logic                w_set_valid;
   logic                w_set_new;

   assign w_clr_valid = i_clr_req & (i_clr_idx != '0) & r_pending[i_clr_idx];
   assign w_set_valid = i_set_en & (i_set_idx != '0);
   // Only count a set that actually adds a bit, so cnt tracks popcount exactly.
   assign w_set_new   = w_set_valid & ~w_pend_eff[i_set_idx];

   always_comb begin
      w_pend_eff = r_pending;
      if (w_clr_valid) w_pend_eff[i_clr_idx] = 1'b0;
   end

   always_comb begin
      w_pend_next = w_pend_eff;
      if (w_set_valid) w_pend_next[i_set_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pending <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_pending <= w_pend_next;
         r_cnt     <= r_cnt + CNT_W'(w_set_new) - CNT_W'(w_clr_valid);
         if (i_clr_req && !w_clr_valid) r_err <= 1'b1;
      end
   end

   assign o_pend_rs1  = w_pend_eff[i_rs1];
   assign o_pend_rs2  = w_pend_eff[i_rs2];
   assign o_pend_rd   = w_pend_eff[i_rd];
   assign o_clr_valid = w_clr_valid;
   assign o_cnt       = r_cnt;
   assign o_err       = r_err;
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/flush producer: load-use, filter-unit RAW/WAW scoreboard, occupancy limit, branch flush.
// Optional perf counters are enabled with HAZARD_PERF_EN.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input logic           i_clk,
   input logic           i_rst,
   hazard_scoreboard_if.slave hz
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic             w_use1, w_use2;
   logic             w_src_hit_e;
   logic             w_e_dst_valid;
   logic             w_load_use, w_long_e_hz, w_sb_raw, w_sb_waw, w_full, w_stall;
   logic             w_pend_rs1, w_pend_rs2, w_pend_rd;
   logic             w_clr_valid;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W:0]   w_occ;
   logic             w_err;
   hz_ctrl_t         w_ctrl;

   sb_pending_vec #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_pend (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_set_en    (hz.i_long_e & hz.i_w_en_e),
      .i_set_idx   (hz.i_rd_e),
      .i_clr_req   (hz.i_long_done),
      .i_clr_idx   (hz.i_long_done_idx),
      .i_rs1       (hz.i_rs1_d),
      .i_rs2       (hz.i_rs2_d),
      .i_rd        (hz.i_rd_d),
      .o_pend_rs1  (w_pend_rs1),
      .o_pend_rs2  (w_pend_rs2),
      .o_pend_rd   (w_pend_rd),
      .o_clr_valid (w_clr_valid),
      .o_cnt       (w_cnt),
      .o_err       (w_err)
   );

   assign w_use1        = hz.i_rs1_used_d & (hz.i_rs1_d != '0);
   assign w_use2        = hz.i_rs2_used_d & (hz.i_rs2_d != '0);
   assign w_e_dst_valid = hz.i_w_en_e & (hz.i_rd_e != '0);
   assign w_src_hit_e   = (w_use1 & (hz.i_rs1_d == hz.i_rd_e)) | (w_use2 & (hz.i_rs2_d == hz.i_rd_e));

   assign w_load_use  = hz.i_mem_read_e & w_e_dst_valid & w_src_hit_e;
   // The issuing filter op is not yet in the scoreboard, so D must also be checked against E directly.
   assign w_long_e_hz = hz.i_long_e & w_e_dst_valid &
                        (w_src_hit_e | (hz.i_w_en_d & (hz.i_rd_d == hz.i_rd_e)));
   assign w_sb_raw    = (w_use1 & w_pend_rs1) | (w_use2 & w_pend_rs2);
   assign w_sb_waw    = hz.i_w_en_d & (hz.i_rd_d != '0) & w_pend_rd;

   assign w_occ   = {1'b0, w_cnt} + (CNT_W+1)'(hz.i_long_e) - (CNT_W+1)'(w_clr_valid);
   assign w_full  = hz.i_long_d & (w_occ >= (CNT_W+1)'(MAX_OUTSTANDING));
   assign w_stall = w_load_use | w_long_e_hz | w_sb_raw | w_sb_waw | w_full;

   always_comb begin
      w_ctrl = '0;
      if (hz.i_branch_taken_e) begin
         w_ctrl.flush_d = 1'b1;
         w_ctrl.flush_e = 1'b1;
      end else begin
         w_ctrl.stall_f = w_stall;
         w_ctrl.stall_d = w_stall;
         w_ctrl.flush_e = w_stall;
      end
   end

   assign hz.o_stall_f = w_ctrl.stall_f;
   assign hz.o_stall_d = w_ctrl.stall_d;
   assign hz.o_flush_d = w_ctrl.flush_d;
   assign hz.o_flush_e = w_ctrl.flush_e;
   assign hz.o_busy    = (w_cnt != '0);
   assign hz.o_err     = w_err;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_ctrl.stall_d && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (hz.i_branch_taken_e && (r_flush_count != '1)) r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign hz.o_stall_cycles = r_stall_cycles;
   assign hz.o_flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_OUTSTANDING=4, default build).
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   logic i_clk = 1'b0;
   logic i_rst;
   int   tests = 0;
   int   fails = 0;

   always #5 i_clk = ~i_clk;

   hazard_scoreboard_if hz();

   hazard_scoreboard #(.MAX_OUTSTANDING(4)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .hz    (hz)
   );

   // {stall_f, stall_d, flush_d, flush_e}
   localparam logic [3:0] C_NONE  = 4'b0000;
   localparam logic [3:0] C_STALL = 4'b1101;
   localparam logic [3:0] C_BR    = 4'b0011;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ctrl();
      return {hz.o_stall_f, hz.o_stall_d, hz.o_flush_d, hz.o_flush_e};
   endfunction

   task automatic idle();
      hz.i_rs1_d = '0; hz.i_rs2_d = '0; hz.i_rs1_used_d = 0; hz.i_rs2_used_d = 0;
      hz.i_rd_d = '0; hz.i_w_en_d = 0; hz.i_long_d = 0;
      hz.i_rd_e = '0; hz.i_w_en_e = 0; hz.i_mem_read_e = 0; hz.i_long_e = 0;
      hz.i_branch_taken_e = 0; hz.i_long_done = 0; hz.i_long_done_idx = '0;
   endtask

   // Advance one clock, then return to idle inputs for the next cycle.
   task automatic cyc();
      @(posedge i_clk); #1;
      idle();
   endtask

   task automatic issue_long(input logic [4:0] rd);
      cyc();
      hz.i_long_e = 1; hz.i_w_en_e = 1; hz.i_rd_e = rd;
   endtask

   task automatic done(input logic [4:0] idx);
      cyc();
      hz.i_long_done = 1; hz.i_long_done_idx = idx;
   endtask

   initial begin
      idle();
      i_rst = 1'b1;
      #12;
      chk("reset_ctrl", 32'(ctrl()), 32'(C_NONE));
      chk("reset_busy", 32'(hz.o_busy), 0);
      chk("reset_err",  32'(hz.o_err), 0);
      i_rst = 1'b0;

      // Load-use: lw x5 in E, add x?,x5 in D
      cyc();
      hz.i_mem_read_e = 1; hz.i_w_en_e = 1; hz.i_rd_e = 5; hz.i_rs1_d = 5; hz.i_rs1_used_d = 1;
      #1 chk("load_use_hit", 32'(ctrl()), 32'(C_STALL));
      cyc();
      hz.i_rs1_d = 5; hz.i_rs1_used_d = 1;
      #1 chk("load_use_released", 32'(ctrl()), 32'(C_NONE));
      cyc();
      hz.i_mem_read_e = 1; hz.i_w_en_e = 1; hz.i_rd_e = 5; hz.i_rs1_d = 6; hz.i_rs1_used_d = 1;
      #1 chk("load_use_miss", 32'(ctrl()), 32'(C_NONE));
      cyc();
      hz.i_mem_read_e = 1; hz.i_w_en_e = 1; hz.i_rd_e = 0; hz.i_rs1_d = 0; hz.i_rs1_used_d = 1;
      #1 chk("load_use_x0", 32'(ctrl()), 32'(C_NONE));

      // Long RAW on x7: D reads x7 via rs2 while the op issues
      issue_long(7);
      hz.i_rs2_d = 7; hz.i_rs2_used_d = 1;
      #1 chk("long_e_hz", 32'(ctrl()), 32'(C_STALL));
      chk("busy_before_issue", 32'(hz.o_busy), 0);
      cyc();
      hz.i_rs2_d = 7; hz.i_rs2_used_d = 1;
      #1 chk("raw_pending", 32'(ctrl()), 32'(C_STALL));
      chk("busy_after_issue", 32'(hz.o_busy), 1);
      cyc();
      hz.i_rs2_d = 7; hz.i_rs2_used_d = 1;
      #1 chk("raw_held", 32'(ctrl()), 32'(C_STALL));
      done(7);
      hz.i_rs2_d = 7; hz.i_rs2_used_d = 1;
      #1 chk("raw_done_cycle", 32'(ctrl()), 32'(C_NONE));
      chk("busy_on_done", 32'(hz.o_busy), 1);
      cyc();
      #1 chk("busy_fall", 32'(hz.o_busy), 0);
      chk("err_clean_done", 32'(hz.o_err), 0);

      // Occupancy limit
      for (int r = 1; r <= 4; r++) issue_long(5'(r));
      cyc();
      hz.i_long_d = 1; hz.i_w_en_d = 1; hz.i_rd_d = 9;
      #1 chk("full_stall", 32'(ctrl()), 32'(C_STALL));
      done(2);
      hz.i_long_d = 1; hz.i_w_en_d = 1; hz.i_rd_d = 9;
      #1 chk("full_relieved_by_done", 32'(ctrl()), 32'(C_NONE));
      issue_long(9);
      #1 chk("issue_x9_no_stall", 32'(ctrl()), 32'(C_NONE));
      cyc();
      hz.i_long_d = 1; hz.i_w_en_d = 1; hz.i_rd_d = 10;
      #1 chk("full_again_cnt4", 32'(ctrl()), 32'(C_STALL));
      // Same-cycle done + issue keeps the count at 4
      done(1);
      hz.i_long_e = 1; hz.i_w_en_e = 1; hz.i_rd_e = 11;
      cyc();
      hz.i_long_d = 1; hz.i_w_en_d = 1; hz.i_rd_d = 10;
      #1 chk("full_after_done_issue", 32'(ctrl()), 32'(C_STALL));

      // Branch priority over an active RAW stall (x3 pending)
      cyc();
      hz.i_rs1_d = 3; hz.i_rs1_used_d = 1;
      #1 chk("raw_x3", 32'(ctrl()), 32'(C_STALL));
      hz.i_branch_taken_e = 1;
      #1 chk("branch_wins", 32'(ctrl()), 32'(C_BR));
      done(3);
      done(4);
      done(9);
      done(11);
      cyc();
      #1 chk("drain_busy", 32'(hz.o_busy), 0);
      chk("drain_err", 32'(hz.o_err), 0);

      // Spurious completion, then async reset mid-flight
      done(12);
      cyc();
      #1 chk("spurious_err", 32'(hz.o_err), 1);
      chk("spurious_busy", 32'(hz.o_busy), 0);
      issue_long(5);
      cyc();
      #1 chk("err_sticky", 32'(hz.o_err), 1);
      chk("busy_x5", 32'(hz.o_busy), 1);
      #1 i_rst = 1'b1;
      #1 chk("async_rst_busy", 32'(hz.o_busy), 0);
      chk("async_rst_err", 32'(hz.o_err), 0);
      i_rst = 1'b0;
      done(5);
      cyc();
      #1 chk("done_after_rst_err", 32'(hz.o_err), 1);
      i_rst = 1'b1;
      #2 i_rst = 1'b0;

      // x0 and untracked long ops
      issue_long(0);
      cyc();
      hz.i_long_e = 1; hz.i_w_en_e = 0; hz.i_rd_e = 8;
      cyc();
      #1 chk("x0_not_tracked", 32'(hz.o_busy), 0);
      hz.i_rs1_d = 8; hz.i_rs1_used_d = 1;
      #1 chk("no_wen_no_raw", 32'(ctrl()), 32'(C_NONE));

      // WAW on x3
      issue_long(3);
      cyc();
      hz.i_w_en_d = 1; hz.i_rd_d = 3;
      #1 chk("waw_stall", 32'(ctrl()), 32'(C_STALL));
      cyc();
      hz.i_w_en_d = 1; hz.i_rd_d = 3;
      #1 chk("waw_held", 32'(ctrl()), 32'(C_STALL));
      done(3);
      hz.i_w_en_d = 1; hz.i_rd_d = 3;
      #1 chk("waw_done_cycle", 32'(ctrl()), 32'(C_NONE));
      cyc();
      #1 chk("waw_busy_fall", 32'(hz.o_busy), 0);
      chk("final_err", 32'(hz.o_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Stall/flush producer for the 5-stage RISC-V core; complements the forwarding unit, which consumes writeback indices.
- Detects the hazards forwarding cannot cover:
  - load-use in D/E;
  - RAW and WAW against results of the multi-cycle WOS filter unit, tracked by a per-register pending scoreboard;
  - taken-branch flush.
- Drives pipeline register enables/clears for the F, D and E stages.

Parameters:
- MAX_OUTSTANDING, 4, maximum concurrent in-flight filter-unit ops (1..31).
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived, localparam).

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous reset, active-high
- i_rs1_d  in  5  D-stage source 1 index
- i_rs2_d  in  5  D-stage source 2 index
- i_rs1_used_d  in  1  D instr reads rs1
- i_rs2_used_d  in  1  D instr reads rs2
- i_rd_d  in  5  D-stage destination index
- i_w_en_d  in  1  D instr writes rd
- i_long_d  in  1  D instr is a filter-unit op
- i_rd_e  in  5  E-stage destination index
- i_w_en_e  in  1  E instr writes rd
- i_mem_read_e  in  1  E instr is a load
- i_long_e  in  1  E instr is a filter-unit op (issues this cycle)
- i_branch_taken_e  in  1  E-stage branch/jump redirect
- i_long_done  in  1  filter-unit completion pulse (result written this cycle)
- i_long_done_idx  in  5  destination of completing op
- o_stall_f  out  1  hold PC
- o_stall_d  out  1  hold IF/ID register
- o_flush_d  out  1  clear IF/ID register
- o_flush_e  out  1  clear ID/EX register (bubble)
- o_busy  out  1  outstanding count non-zero
- o_err  out  1  sticky: completion for a non-pending register

Behaviour:
- State:
  - pending[31:1] register vector; x0 is never pending.
  - Counter cnt[CNT_W-1:0].
  - Sticky o_err.
  - Reset (async, i_rst=1) clears all three; reset mid-operation discards in-flight tracking, and later done pulses then raise o_err.
- Hazard terms (combinational, same cycle):
  - use1 = i_rs1_used_d & i_rs1_d!=0; use2 likewise.
  - load_use = i_mem_read_e & i_w_en_e & i_rd_e!=0 & ((use1 & i_rs1_d==i_rd_e) | (use2 & i_rs2_d==i_rd_e)).
  - long_e_hz = i_long_e & i_w_en_e & i_rd_e!=0 & (rs1/rs2 match i_rd_e as above, or i_w_en_d & i_rd_d==i_rd_e).
  - sb_raw = (use1 & pending[i_rs1_d]) | (use2 & pending[i_rs2_d]), evaluated after same-cycle clear: a register completing this cycle is not pending (the result is forwarded via W).
  - sb_waw = i_w_en_d & i_rd_d!=0 & pending[i_rd_d] (after clear).
  - full = i_long_d & (cnt + i_long_e - i_long_done_valid) >= MAX_OUTSTANDING.
  - stall = load_use | long_e_hz | sb_raw | sb_waw | full.
- Outputs:
  - Branch priority: if i_branch_taken_e, then o_flush_d=1, o_flush_e=1, o_stall_f=0, o_stall_d=0 (redirect wins over stall).
  - Else o_stall_f = o_stall_d = o_flush_e = stall and o_flush_d = 0.
- Sequential update, each posedge:
  - Clear: if i_long_done & i_long_done_idx!=0 & pending[idx], clear the bit and decrement cnt (i_long_done_valid); otherwise i_long_done raises o_err with no count change.
  - Set: if i_long_e & i_w_en_e & i_rd_e!=0, set pending[i_rd_e] and increment cnt.
  - Order: clear before set, so on the same index set wins. Same-cycle done + issue leaves cnt unchanged.
  - A long op with rd=0 or !w_en is not tracked and not counted.
- Invariant: cnt == popcount(pending); the counter never exceeds MAX_OUTSTANDING and never underflows.
- o_busy = cnt!=0, registered-derived.
- All hazard outputs are 0 latency; scoreboard state takes effect 1 cycle after issue.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds output o_stall_cycles [31:0], a saturating count of cycles with o_stall_d=1, cleared by reset.
  - Adds output o_flush_count [15:0], a saturating count of i_branch_taken_e cycles.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared core package:
  - REG_IDX_W=5 and NUM_REGS=32 constants.
  - A typedef for the stall/flush control bundle, reused by the pipeline top.
- One sub-module, sb_pending_vec: pending vector plus counter with set/clear ports and combinational lookup outputs.
- Hazard logic stays in the parent.

Test Plan:
- Load-use: E: lw x5 (i_mem_read_e=1, i_rd_e=5), D: add rs1=5 -> stall_f/stall_d/flush_e=1 for exactly 1 cycle; with rs1=6 -> all 0.
- Long RAW: issue long rd=7; next cycle D reads x7 -> stall held until i_long_done idx=7; on the done cycle stall=0, pending[7] cleared, cnt 1->0, o_busy falls next cycle.
- Full: MAX_OUTSTANDING=4, issue long to x1..x4 -> cnt=4; D long to x9 -> stall; done idx=2 in the same cycle -> no stall, cnt stays 4 after issue.
- Branch priority: i_branch_taken_e=1 during an active sb_raw stall -> flush_d=flush_e=1, stall_f=stall_d=0.
- Spurious done: i_long_done idx=12 with nothing pending -> o_err=1 sticky, cnt unchanged; i_rst pulse mid-flight -> pending=0, cnt=0, o_err=0 asynchronously.
- x0 / WAW: long rd=0 -> cnt stays 0; pending x3 plus D write rd=3 -> stall until done.
